fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 Parameter ADDR_WIDTH, default ADDR_WIDTH_32 (32), the PC and memory address width.
REQ-003 Parameter DATA_WIDTH, default DATA_WIDTH_32 (32), the instruction width.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port imem_addr, output, ADDR_WIDTH: address driven to the combinational-read instruction memory.
REQ-007 Port imem_instruction, input, DATA_WIDTH: instruction word returned in the same cycle for imem_addr.
REQ-008 Port redirect_valid, input, 1: branch/jump redirect request.
REQ-009 Port redirect_pc, input, ADDR_WIDTH: redirect target.
REQ-010 Port out_valid, output, 1: the head of the fetch buffer is valid.
REQ-011 Port out_ready, input, 1: the consumer accepts the head this cycle.
REQ-012 Port out_instruction / out_pc, output, DATA_WIDTH / ADDR_WIDTH: head instruction and its address.
REQ-013 Port misaligned_fault, output, 1: sticky fault, PC[1:0] != 0.
REQ-014 Port fetch_count, output, 32: count of accepted instructions (see Configuration).

Function
REQ-015 The block SHALL hold a PC register and a 2-entry FIFO buffer of {pc, instruction}.
REQ-016 The FSM SHALL have states RUN, FULL, and FAULT.
REQ-017 imem_addr SHALL equal PC combinationally in every state.
REQ-018 In RUN, the block SHALL push {PC, imem_instruction} into the buffer each cycle and set PC <= PC + 4 (modulo 2^ADDR_WIDTH; 32'hFFFF_FFFC wraps to 0).
REQ-019 A push in the same cycle as a pop SHALL be allowed when the buffer holds 2 entries.
REQ-020 The FSM SHALL enter FULL when 2 entries are held and no pop occurs; in FULL the PC SHALL hold and no push SHALL occur.
REQ-021 The FSM SHALL return from FULL to RUN on the cycle after a pop.
REQ-022 A pop SHALL occur when out_valid && out_ready; out_valid SHALL be 1 iff the buffer is non-empty.
REQ-023 out_instruction and out_pc SHALL be stable while out_valid && !out_ready.
REQ-024 If PC[1:0] != 0 while in RUN, the block SHALL NOT push, SHALL enter FAULT, and SHALL set misaligned_fault = 1 on the next cycle.
REQ-025 In FAULT, PC SHALL hold, pushes SHALL stop, buffered entries SHALL continue to drain, and misaligned_fault SHALL stay 1.
REQ-026 redirect_valid SHALL take priority over every push and pop: the buffer is flushed (empty next cycle), PC <= redirect_pc, and the FSM moves to RUN.
REQ-027 A redirect SHALL clear misaligned_fault; a misaligned redirect_pc SHALL raise the fault again per REQ-024.
REQ-028 Latency: the instruction at address A SHALL appear on out_instruction 1 cycle after PC == A in RUN.
REQ-029 A redirect target SHALL appear at out_pc 2 cycles after the cycle in which redirect_valid is sampled.

Reset
REQ-030 On assertion of rst_n = 0, the block SHALL immediately set PC = RESET_PC, empty the buffer, set the FSM to RUN, and force out_valid = 0, misaligned_fault = 0, and fetch_count = 0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered entries, including any pending redirect.
REQ-032 The first push SHALL occur on the first rising edge after rst_n deasserts.

Configuration
REQ-033 With FETCH_PERF_CNT_EN defined, fetch_count SHALL increment by 1 per pop, wrapping at 2^32, and SHALL NOT be cleared by a redirect.
REQ-034 Without FETCH_PERF_CNT_EN, fetch_count SHALL be tied to 0 and the counter SHALL NOT be synthesised.

Verification
REQ-035 Reset release, out_ready = 1, memory word = address -> out_pc sequence 0, 4, 8 on consecutive cycles, with out_valid = 1 from the cycle after the first push.
REQ-036 out_ready = 0 for 5 cycles from reset -> buffer holds out_pc 0 and 4, PC holds at 8, and out_pc stays 0; on the first out_ready = 1 the sequence resumes 0, 4, 8 with no gap or duplicate.
REQ-037 Redirect to 32'h40 with 2 entries buffered -> both entries discarded and the next valid out_pc = 32'h40.
REQ-038 Redirect to 32'h0000_0006 -> no push, misaligned_fault = 1 and held; a following redirect to 32'h10 clears it and out_pc = 32'h10.
REQ-039 Redirect to 32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 With FETCH_PERF_CNT_EN defined, 10 accepted handshakes -> fetch_count = 10; then rst_n = 0 -> fetch_count = 0 and out_valid = 0 asynchronously.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch front end: PC register, 2-entry {pc, instruction} buffer and RUN/FULL/FAULT FSM.
// Optional accepted-instruction counter on fetch_count when FETCH_PERF_CNT_EN is defined.
//
// state | meaning
// RUN   | fetching: push {pc, imem_instruction} and advance PC whenever a slot is free
// FULL  | buffer held 2 entries for a cycle with no pop; PC frozen until the next pop
// FAULT | PC misaligned; fetch stopped, buffer drains, only a redirect leaves this state
module fetch_controller #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_instruction,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instruction,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  misaligned_fault,
  output logic [31:0]           fetch_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FULL  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] buf0_pc_q, buf0_pc_d, buf1_pc_q, buf1_pc_d;
  logic [DATA_WIDTH-1:0] buf0_ins_q, buf0_ins_d, buf1_ins_q, buf1_ins_d;

  logic pop;
  logic push;
  logic wr_sel;

  assign imem_addr        = pc_q;
  assign out_valid        = (cnt_q != 2'd0);
  assign out_pc           = buf0_pc_q;
  assign out_instruction  = buf0_ins_q;
  assign misaligned_fault = (state_q == ST_FAULT);

  // A redirect swallows the consumer handshake, so it never counts as a pop.
  assign pop = out_valid && out_ready && !redirect_valid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    push       = 1'b0;
    if (redirect_valid) begin
      state_d = ST_RUN;
      pc_d    = redirect_pc;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pc_q[1:0] != 2'b00) begin
            state_d = ST_FAULT;
          end else if ((cnt_q == 2'd2) && !pop) begin
            state_d = ST_FULL;
          end else begin
            push = 1'b1;
            pc_d = pc_q + ADDR_WIDTH'(4);
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d = ST_RUN;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Slot 1 is written when the head stays occupied after this cycle's pop.
  assign wr_sel = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !pop);

  always_comb begin
    cnt_d      = cnt_q;
    buf0_pc_d  = buf0_pc_q;
    buf0_ins_d = buf0_ins_q;
    buf1_pc_d  = buf1_pc_q;
    buf1_ins_d = buf1_ins_q;
    if (redirect_valid) begin
      cnt_d = 2'd0;
    end else begin
      if (pop) begin
        buf0_pc_d  = buf1_pc_q;
        buf0_ins_d = buf1_ins_q;
      end
      if (push) begin
        if (wr_sel) begin
          buf1_pc_d  = pc_q;
          buf1_ins_d = imem_instruction;
        end else begin
          buf0_pc_d  = pc_q;
          buf0_ins_d = imem_instruction;
        end
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      cnt_q      <= 2'd0;
      buf0_pc_q  <= '0;
      buf0_ins_q <= '0;
      buf1_pc_q  <= '0;
      buf1_ins_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      buf0_pc_q  <= buf0_pc_d;
      buf0_ins_q <= buf0_ins_d;
      buf1_pc_q  <= buf1_pc_d;
      buf1_ins_q <= buf1_ins_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (pop) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_q <= 32'd0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign fetch_count = perf_cnt_q;
`else
  assign fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus random redirect/ready traffic
// compared against a queue-based reference model.
module tb_fetch_controller;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        misaligned_fault;
  logic [31:0] fetch_count;
  logic [31:0] salt;

  int n_checks = 0;
  int n_errors = 0;

  fetch_controller #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_instruction(imem_instruction),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .misaligned_fault(misaligned_fault),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: each word is its address xor a per-phase salt.
  always_comb imem_instruction = imem_addr ^ salt;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_fault;
  logic        m_stall;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef FETCH_PERF_CNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc    = RST_PC;
    m_fault = 1'b0;
    m_stall = 1'b0;
    m_cnt   = 32'd0;
  endtask

  // One clock of the spec's fetch rules applied to the model.
  task automatic model_step(input logic rv, input logic [31:0] rp, input logic rdy);
    int  n_before;
    logic pop;
    if (rv) begin
      m_q.delete();
      m_pc    = rp;
      m_fault = 1'b0;
      m_stall = 1'b0;
      return;
    end
    n_before = m_q.size();
    pop      = (n_before != 0) && rdy;
    if (pop) begin
      void'(m_q.pop_front());
      m_cnt = m_cnt + 32'd1;
    end
    if (m_fault) begin
      // fetch stopped until a redirect
    end else if (m_pc[1:0] != 2'b00) begin
      m_fault = 1'b1;
    end else if (m_stall) begin
      if (pop) m_stall = 1'b0;
    end else if ((n_before == 2) && !pop) begin
      m_stall = 1'b1;
    end else begin
      m_q.push_back('{pc: m_pc, ins: m_pc ^ salt});
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("out_pc", out_pc, m_q[0].pc);
      chk("out_instruction", out_instruction, m_q[0].ins);
    end
    chk("imem_addr", imem_addr, m_pc);
    chk("misaligned_fault", {31'd0, misaligned_fault}, {31'd0, m_fault});
    chk("fetch_count", fetch_count, exp_cnt());
  endtask

  // Called at a falling edge: drive inputs, check, advance model on the rising edge.
  task automatic cycle(input logic rv, input logic [31:0] rp, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = rdy;
    #1;
    check_outputs();
    @(posedge clk);
    model_step(rv, rp, rdy);
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle with a redirect pending, released on a falling edge.
  task automatic do_reset();
    #2;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1234;
    rst_n          = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_fault", {31'd0, misaligned_fault}, 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_valid", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b0;
    rst_n          = 1'b1;
  endtask

  initial begin
    logic [31:0] rp;
    logic        rv, rdy;
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b0;
    salt           = 32'd0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Streaming with the consumer always ready.
    cycle(1'b0, 32'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("stream_pc", out_pc, 32'(k * 4));
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      cycle(1'b0, 32'd0, 1'b1);
    end

    // Back-pressure from reset, then resume without gap or duplicate.
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1'b0, 32'd0, 1'b0);
    chk("stall_head_pc", out_pc, 32'h0);
    chk("stall_pc_hold", imem_addr, 32'h8);
    for (int k = 0; k < 3; k++) begin
      chk("resume_pc", out_pc, 32'(k * 4));
      cycle(1'b0, 32'd0, 1'b1);
    end

    // Redirect with two entries buffered.
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b1, 32'h40, 1'b0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    cycle(1'b0, 32'd0, 1'b0);
    chk("redirect_target", out_pc, 32'h40);

    // Misaligned redirect, then recovery.
    cycle(1'b1, 32'h6, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("fault_sticky", {31'd0, misaligned_fault}, 32'd1);
      chk("fault_no_push", {31'd0, out_valid}, 32'd0);
      cycle(1'b0, 32'd0, 1'b1);
    end
    cycle(1'b1, 32'h10, 1'b1);
    chk("fault_cleared", {31'd0, misaligned_fault}, 32'd0);
    cycle(1'b0, 32'd0, 1'b1);
    chk("recover_pc", out_pc, 32'h10);

    // Address wrap.
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    chk("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    cycle(1'b0, 32'd0, 1'b1);
    chk("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    cycle(1'b0, 32'd0, 1'b1);
    chk("wrap_pc2", out_pc, 32'h0000_0000);

    // Ten accepted handshakes, then asynchronous reset clears the count.
    do_reset();
    for (int k = 0; k < 11; k++) cycle(1'b0, 32'd0, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    chk("count_ten", fetch_count, 32'd10);
`else
    chk("count_tied", fetch_count, 32'd0);
`endif
    do_reset();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ((i % 700) == 699) begin
        salt = $urandom;
        do_reset();
      end
      rv  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       rp = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} & 32'hFFFF_FFFC;
        1:       rp = $urandom;
        2:       rp = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
        default: rp = 32'($urandom_range(0, 63) * 4);
      endcase
      cycle(rv, rp, rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
